// File: rtl/byte_serial_tx_pkg.sv
// Shared types and constants for the byte-serial transmitter.
package byte_serial_tx_pkg;

  // Transmit FSM states, in frame order.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/byte_serial_tx_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO. The head entry is
// presented on pop_data whenever the FIFO is not empty. Pushes while full
// and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (level_r == LVL_W'(DEPTH));
  assign empty_s   = (level_r == {LVL_W{1'b0}});
  assign do_push_s = push & ~full_s;
  assign do_pop_s  = pop & ~empty_s;

  assign full     = full_s;
  assign empty    = empty_s;
  assign level    = level_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Storage array: written on accepted pushes, contents not reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + {{(LVL_W-1){1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{(LVL_W-1){1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/byte_serial_tx.sv
// Byte-serial transmitter: buffers bytes from the upstream stage in a FIFO
// and sends each as start, 8 data bits LSB-first, even parity, stop.
module byte_serial_tx
  import byte_serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_t         state_r;
  tx_state_t         state_next_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [CNT_W-1:0]  bit_cnt_next_s;
  logic [IDX_W-1:0]  bit_idx_r;
  logic [IDX_W-1:0]  bit_idx_next_s;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] shift_next_s;
  logic              parity_r;
  logic              parity_next_s;
  logic              tx_out_r;
  logic              tx_out_next_s;
  logic              tx_busy_r;
  logic              tx_busy_next_s;
  logic              bit_end_s;
  logic              pop_s;

  logic [DATA_W-1:0]               fifo_head_s;
  logic                            fifo_full_s;
  logic                            fifo_empty_s;
  logic [$clog2(FIFO_DEPTH):0]     fifo_level_s;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level_s)
  );

  // The FIFO ignores pushes while full, so in_ready alone gates the transfer.
  assign in_ready   = ~fifo_full_s;
  assign fifo_level = fifo_level_s;
  assign tx_out     = tx_out_r;
  assign tx_busy    = tx_busy_r;

  assign bit_end_s = (bit_cnt_r == CNT_LAST);

  // Next-state logic: bit timing, shifting, head pop and registered line value.
  always_comb begin
    state_next_s   = state_r;
    bit_cnt_next_s = bit_cnt_r;
    bit_idx_next_s = bit_idx_r;
    shift_next_s   = shift_r;
    parity_next_s  = parity_r;
    pop_s          = 1'b0;
    tx_out_next_s  = 1'b1;
    tx_busy_next_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s          = 1'b1;
          shift_next_s   = fifo_head_s;
          parity_next_s  = even_parity(fifo_head_s);
          bit_cnt_next_s = {CNT_W{1'b0}};
          state_next_s   = START;
        end else begin
          bit_cnt_next_s = {CNT_W{1'b0}};
        end
      end
      START: begin
        if (bit_end_s) begin
          bit_cnt_next_s = {CNT_W{1'b0}};
          bit_idx_next_s = {IDX_W{1'b0}};
          state_next_s   = DATA;
        end else begin
          bit_cnt_next_s = bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DATA: begin
        if (bit_end_s) begin
          bit_cnt_next_s = {CNT_W{1'b0}};
          if (bit_idx_r == IDX_LAST) begin
            state_next_s = PARITY;
          end else begin
            shift_next_s   = {1'b0, shift_r[DATA_W-1:1]};
            bit_idx_next_s = bit_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          bit_cnt_next_s = bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          bit_cnt_next_s = {CNT_W{1'b0}};
          state_next_s   = STOP;
        end else begin
          bit_cnt_next_s = bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      STOP: begin
        if (bit_end_s) begin
          bit_cnt_next_s = {CNT_W{1'b0}};
          // Chain straight into the next frame when a byte is waiting.
          if (!fifo_empty_s) begin
            pop_s         = 1'b1;
            shift_next_s  = fifo_head_s;
            parity_next_s = even_parity(fifo_head_s);
            state_next_s  = START;
          end else begin
            state_next_s  = IDLE;
          end
        end else begin
          bit_cnt_next_s = bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        bit_cnt_next_s = {CNT_W{1'b0}};
        state_next_s   = IDLE;
      end
    endcase

    // Line value is derived from the state being entered so tx_out can be a flop.
    case (state_next_s)
      IDLE:    tx_out_next_s = 1'b1;
      START:   tx_out_next_s = 1'b0;
      DATA:    tx_out_next_s = shift_next_s[0];
      PARITY:  tx_out_next_s = parity_next_s;
      STOP:    tx_out_next_s = 1'b1;
      default: tx_out_next_s = 1'b1;
    endcase

    tx_busy_next_s = (state_next_s != IDLE);
  end

  // FSM state, bit timing, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= {CNT_W{1'b0}};
      bit_idx_r <= {IDX_W{1'b0}};
      shift_r   <= {DATA_W{1'b0}};
      parity_r  <= 1'b0;
      tx_out_r  <= 1'b1;
      tx_busy_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      bit_cnt_r <= bit_cnt_next_s;
      bit_idx_r <= bit_idx_next_s;
      shift_r   <= shift_next_s;
      parity_r  <= parity_next_s;
      tx_out_r  <= tx_out_next_s;
      tx_busy_r <= tx_busy_next_s;
    end
  end

endmodule

// File: tb/tb_byte_serial_tx.sv
// Scoreboard bench for byte_serial_tx: accepted bytes are queued, a serial
// decoder rebuilds each frame from tx_out and compares against the queue.
module tb_byte_serial_tx;

  localparam int C  = 4;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;
  localparam int FL = 11 * C;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          tx_out;
  logic          tx_busy;
  logic [LW-1:0] fifo_level;

  int checks = 0;
  int errors = 0;

  byte_serial_tx #(
    .DATA_W       (8),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] sb_q[$];

  // Serial decoder state
  bit         mon_in = 1'b0;
  int         mon_k;
  int         mon_b;
  logic [10:0] mon_bits;
  bit         mon_glitch;
  bit         mon_nobusy;
  int         frames = 0;
  logic [7:0] last_data;
  logic       last_par;
  logic [7:0] exp_b;

  // Decode one frame from the line, sampling every cycle on the falling edge.
  always @(negedge clk) begin
    if (!mon_in && tx_out === 1'b0 && rst === 1'b0) begin
      mon_in     = 1'b1;
      mon_k      = 0;
      mon_glitch = 1'b0;
      mon_nobusy = 1'b0;
    end
    if (mon_in) begin
      mon_b = mon_k / C;
      if (mon_k % C == 0) mon_bits[mon_b] = tx_out;
      else if (tx_out !== mon_bits[mon_b]) mon_glitch = 1'b1;
      if (tx_busy !== 1'b1) mon_nobusy = 1'b1;
      mon_k++;
      if (mon_k == FL) begin
        mon_in    = 1'b0;
        frames++;
        last_data = mon_bits[8:1];
        last_par  = mon_bits[9];
        chk("start_bit", mon_bits[0], 1'b0);
        chk("stop_bit", mon_bits[10], 1'b1);
        chk("bit_hold", mon_glitch, 1'b0);
        chk("busy_in_frame", mon_nobusy, 1'b0);
        chk("sb_nonempty", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          exp_b = sb_q.pop_front();
          chk("frame_data", mon_bits[8:1], exp_b);
          chk("frame_parity", mon_bits[9], ^exp_b);
        end
      end
    end
  end

  // Reset discards queued bytes and any partial frame.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      mon_in = 1'b0;
      sb_q.delete();
    end
  end

  int busy_run = 0;
  int last_run = 0;
  int peak = 0;
  bit busy_seen = 1'b0;

  // Length of each contiguous tx_busy run, plus fifo peak tracking.
  always @(negedge clk) begin
    if (tx_busy === 1'b1) begin
      busy_run++;
      busy_seen = 1'b1;
    end else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
  end

  task automatic push_byte(input logic [7:0] b, output int stall);
    stall = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && stall < 500) begin
      stall++;
      @(negedge clk);
    end
    chk("push_accept", in_ready, 1'b1);
    if (in_ready) begin
      sb_q.push_back(b);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_busy === 1'b0 && fifo_level == '0 && !mon_in) && n < lim);
    chk("idle_reached", n < lim, 1'b1);
    @(negedge clk);
  endtask

  int st;
  int f0;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_tx_out", tx_out, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_level", fifo_level, 0);
    end

    // Single byte 0xA5: latency, content, frame length
    f0 = frames;
    push_byte(8'hA5, st);
    @(negedge clk);
    chk("lat_tx_hi", tx_out, 1'b1);
    chk("lat_level1", fifo_level, 1);
    @(negedge clk);
    chk("lat_tx_lo", tx_out, 1'b0);
    chk("lat_busy", tx_busy, 1'b1);
    chk("lat_level0", fifo_level, 0);
    wait_idle(500);
    chk("a5_frames", frames - f0, 1);
    chk("a5_data", last_data, 8'hA5);
    chk("a5_par", last_par, 1'b0);
    chk("a5_busy_len", last_run, FL);

    // Parity corner cases
    push_byte(8'h07, st);
    wait_idle(500);
    chk("p07_data", last_data, 8'h07);
    chk("p07_par", last_par, 1'b1);
    push_byte(8'h00, st);
    wait_idle(500);
    chk("p00_data", last_data, 8'h00);
    chk("p00_par", last_par, 1'b0);

    // Burst of five, then a stalled sixth; all frames back-to-back
    f0   = frames;
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      push_byte(8'(i * 8'h11), st);
      chk("burst_no_stall", st, 0);
    end
    chk("burst_level4", fifo_level, 4);
    chk("burst_ready_lo", in_ready, 1'b0);
    push_byte(8'h66, st);
    chk("sixth_stalled", st > 0, 1'b1);
    chk("sixth_level", fifo_level, 4);
    wait_idle(2000);
    chk("burst_peak", peak, 4);
    chk("burst_frames", frames - f0, 6);
    chk("burst_run", last_run, 6 * FL);

    // Reset mid-frame with three bytes queued
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i), st);
    repeat (6) @(negedge clk);
    chk("pre_rst_level", fifo_level, 3);
    chk("pre_rst_busy", tx_busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", tx_out, 1'b1);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_busy", tx_busy, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    f0        = frames;
    busy_seen = 1'b0;
    repeat (100) @(negedge clk);
    chk("post_rst_frames", frames - f0, 0);
    chk("post_rst_quiet", busy_seen, 1'b0);

    // Random 50% upstream valid over 200 bytes
    f0 = frames;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 0) @(posedge clk);
      push_byte(8'($urandom_range(0, 255)), st);
    end
    wait_idle(20000);
    chk("rand_frames", frames - f0, 200);
    chk("rand_sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
